// File: rtl/delivery_scheduler.sv
// Turns the shared 4-bit LFSR nibble into ball-by-ball cricket outcomes.
// It also keeps the innings totals and ends the innings on the over or wicket limit.
module delivery_scheduler #(
  parameter int ROLL_CYCLES    = 8,
  parameter int BALLS_PER_OVER = 6,
  parameter int OVERS          = 2,
  parameter int MAX_WICKETS    = 10
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic [3:0] rand_in,
  input  logic       bowl,
  input  logic       new_innings,
  input  logic       result_ack,
  output logic       result_valid,
  output logic [2:0] outcome_runs,
  output logic       outcome_wicket,
  output logic [8:0] score,
  output logic [3:0] wickets,
  output logic [2:0] balls_in_over,
  output logic [3:0] overs_done,
  output logic       busy,
  output logic       innings_over
);

  // state  | meaning
  // IDLE   | waiting for a bowl request
  // ROLL   | decorrelation window, counter runs up to ROLL_CYCLES-1
  // UPDATE | map captured nibble, update totals
  // SHOW   | result presented, waiting for result_ack
  // DONE   | innings finished, only reset/new_innings leave
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ROLL   = 3'd1,
    S_UPDATE = 3'd2,
    S_SHOW   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [7:0] ROLL_LAST = 8'(ROLL_CYCLES - 1);
  localparam logic [2:0] BALL_LAST = 3'(BALLS_PER_OVER - 1);
  localparam logic [3:0] OVER_LIM  = 4'(OVERS);
  localparam logic [3:0] WKT_LIM   = 4'(MAX_WICKETS);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_roll_cnt;
  logic [3:0] r_nibble;
  logic [2:0] r_runs;
  logic       r_wicket;
  logic [8:0] r_score;
  logic [3:0] r_wickets;
  logic [2:0] r_balls;
  logic [3:0] r_overs;

  logic [2:0] w_runs;
  logic       w_wicket;
  logic [9:0] w_score_sum;
  logic [8:0] w_score_nxt;
  logic       w_roll_end;

  assign w_roll_end = (r_roll_cnt == ROLL_LAST);

  always_comb begin
    w_runs   = 3'd0;
    w_wicket = 1'b0;
    if (r_nibble <= 4'd2)       w_runs = 3'd0;
    else if (r_nibble <= 4'd6)  w_runs = 3'd1;
    else if (r_nibble <= 4'd8)  w_runs = 3'd2;
    else if (r_nibble == 4'd9)  w_runs = 3'd3;
    else if (r_nibble <= 4'd11) w_runs = 3'd4;
    else if (r_nibble <= 4'd13) w_runs = 3'd6;
    else                        w_wicket = 1'b1;
  end

  assign w_score_sum = {1'b0, r_score} + {7'd0, w_runs};
  assign w_score_nxt = w_score_sum[9] ? 9'd511 : w_score_sum[8:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bowl) w_state_nxt = S_ROLL;
      S_ROLL:   if (w_roll_end) w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = S_SHOW;
      S_SHOW: begin
        // limits are checked on the totals already updated for this ball
        if (result_ack)
          w_state_nxt = ((r_wickets == WKT_LIM) || (r_overs == OVER_LIM)) ? S_DONE : S_IDLE;
      end
      S_DONE:   w_state_nxt = S_DONE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_fpga) begin
    if (reset || new_innings) begin
      r_state    <= S_IDLE;
      r_roll_cnt <= 8'd0;
      r_nibble   <= 4'd0;
      r_runs     <= 3'd0;
      r_wicket   <= 1'b0;
      r_score    <= 9'd0;
      r_wickets  <= 4'd0;
      r_balls    <= 3'd0;
      r_overs    <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (bowl) r_roll_cnt <= 8'd0;
        S_ROLL: begin
          r_roll_cnt <= r_roll_cnt + 8'd1;
          if (w_roll_end) r_nibble <= rand_in;
        end
        S_UPDATE: begin
          r_runs   <= w_runs;
          r_wicket <= w_wicket;
          r_score  <= w_score_nxt;
          if (w_wicket) r_wickets <= r_wickets + 4'd1;
          if (r_balls == BALL_LAST) begin
            r_balls <= 3'd0;
            r_overs <= r_overs + 4'd1;
          end else begin
            r_balls <= r_balls + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_valid   = (r_state == S_SHOW);
  assign busy           = (r_state == S_ROLL) || (r_state == S_UPDATE) || (r_state == S_SHOW);
  assign innings_over   = (r_state == S_DONE);
  assign outcome_runs   = r_runs;
  assign outcome_wicket = r_wicket;
  assign score          = r_score;
  assign wickets        = r_wickets;
  assign balls_in_over  = r_balls;
  assign overs_done     = r_overs;

endmodule

// File: tb/tb_delivery_scheduler.sv
// Randomized self-checking bench for delivery_scheduler against an arithmetic innings model.
// A second instance with long innings exercises score saturation.
module tb_delivery_scheduler;

  localparam int R   = 8;
  localparam int BPO = 6;
  localparam int OV  = 2;
  localparam int MW  = 10;

  logic clk_fpga = 1'b0;
  always #5 clk_fpga = ~clk_fpga;

  // main instance (default parameters)
  logic       m_rst = 1'b0, m_bowl = 1'b0, m_new = 1'b0, m_ack = 1'b0;
  logic [3:0] m_rand = 4'd0;
  logic       m_valid, m_wkt, m_busy, m_over;
  logic [2:0] m_runs, m_balls;
  logic [8:0] m_score;
  logic [3:0] m_wkts, m_overs;

  delivery_scheduler #(.ROLL_CYCLES(R), .BALLS_PER_OVER(BPO), .OVERS(OV), .MAX_WICKETS(MW)) u_dut (
    .clk_fpga(clk_fpga), .reset(m_rst), .rand_in(m_rand), .bowl(m_bowl),
    .new_innings(m_new), .result_ack(m_ack), .result_valid(m_valid),
    .outcome_runs(m_runs), .outcome_wicket(m_wkt), .score(m_score), .wickets(m_wkts),
    .balls_in_over(m_balls), .overs_done(m_overs), .busy(m_busy), .innings_over(m_over));

  // long-innings instance for saturation
  logic       s_rst = 1'b0, s_bowl = 1'b0, s_new = 1'b0, s_ack = 1'b0;
  logic [3:0] s_rand = 4'd0;
  logic       s_valid, s_wkt, s_busy, s_over;
  logic [2:0] s_runs, s_balls;
  logic [8:0] s_score;
  logic [3:0] s_wkts, s_overs;

  delivery_scheduler #(.ROLL_CYCLES(1), .BALLS_PER_OVER(7), .OVERS(15), .MAX_WICKETS(10)) u_sat (
    .clk_fpga(clk_fpga), .reset(s_rst), .rand_in(s_rand), .bowl(s_bowl),
    .new_innings(s_new), .result_ack(s_ack), .result_valid(s_valid),
    .outcome_runs(s_runs), .outcome_wicket(s_wkt), .score(s_score), .wickets(s_wkts),
    .balls_in_over(s_balls), .overs_done(s_overs), .busy(s_busy), .innings_over(s_over));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // innings model: totals kept as plain counts
  int md_score, md_wkts, md_balls, md_runs, md_wkt;

  function automatic int map_runs(input int nib);
    if (nib <= 2)  return 0;
    if (nib <= 6)  return 1;
    if (nib <= 8)  return 2;
    if (nib == 9)  return 3;
    if (nib <= 11) return 4;
    if (nib <= 13) return 6;
    return 0;
  endfunction

  function automatic int model_done();
    return ((md_wkts == MW) || (md_balls / BPO == OV)) ? 1 : 0;
  endfunction

  task automatic model_clear();
    md_score = 0; md_wkts = 0; md_balls = 0; md_runs = 0; md_wkt = 0;
  endtask

  task automatic model_ball(input int nib);
    md_runs  = map_runs(nib);
    md_wkt   = (nib >= 14) ? 1 : 0;
    md_score = (md_score + md_runs > 511) ? 511 : md_score + md_runs;
    md_wkts += md_wkt;
    md_balls++;
  endtask

  task automatic check_totals(input string tag);
    chk({tag, ".runs"},   m_runs,  md_runs);
    chk({tag, ".wkt"},    m_wkt,   md_wkt);
    chk({tag, ".score"},  m_score, md_score);
    chk({tag, ".wkts"},   m_wkts,  md_wkts);
    chk({tag, ".balls"},  m_balls, md_balls % BPO);
    chk({tag, ".overs"},  m_overs, md_balls / BPO);
  endtask

  task automatic tick();
    @(posedge clk_fpga);
    #1;
  endtask

  task automatic clear_main(input bit use_new);
    if (use_new) m_new = 1'b1; else m_rst = 1'b1;
    tick();
    m_new = 1'b0; m_rst = 1'b0;
    model_clear();
    chk("clr.valid", m_valid, 0);
    chk("clr.busy",  m_busy,  0);
    chk("clr.over",  m_over,  0);
    check_totals("clr");
  endtask

  // one delivery; rand_in carries the wanted nibble only in the sample cycle
  task automatic deliver(input int nib, input int hold);
    int n;
    bit busy_ok, show_ok;
    int score_before;
    m_bowl = 1'b1;
    m_rand = 4'($urandom_range(0, 15));
    tick();
    m_bowl = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    while (!m_valid && n < 60) begin
      m_rand = (n == R) ? 4'(nib) : 4'($urandom_range(0, 15));
      if (!m_busy) busy_ok = 1'b0;
      if (n % 3 == 0) m_bowl = 1'b1; else m_bowl = 1'b0;
      tick();
      n++;
    end
    m_bowl = 1'b0;
    chk("latency", n, R + 2);
    chk("busy_roll", busy_ok, 1);
    model_ball(nib);
    check_totals("show");
    chk("show.busy", m_busy, 1);
    score_before = m_score;
    show_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      m_bowl = 1'($urandom_range(0, 1));
      m_rand = 4'($urandom_range(0, 15));
      tick();
      if (!m_valid || !m_busy || m_score != score_before) show_ok = 1'b0;
    end
    if (hold > 0) chk("show.hold", show_ok, 1);
    m_ack  = 1'b1;
    m_bowl = 1'($urandom_range(0, 1));
    tick();
    m_ack  = 1'b0;
    m_bowl = 1'b0;
    chk("ack.valid", m_valid, 0);
    chk("ack.busy",  m_busy,  0);
    chk("ack.over",  m_over,  model_done());
    tick();
    chk("idle.busy", m_busy, 0);
    check_totals("idle");
  endtask

  task automatic sat_deliver(input int nib, output int ok);
    int n;
    s_bowl = 1'b1;
    tick();
    s_bowl = 1'b0;
    s_rand = 4'(nib);
    n = 0;
    while (!s_valid && n < 20) begin
      tick();
      n++;
    end
    ok = s_valid ? 1 : 0;
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ok, sat_exp, seen;
    bit dbusy;
    model_clear();
    tick();
    clear_main(1'b0);

    // first ball: six runs, long hold with bowl noise
    deliver(12, 20);

    // dot-ish singles through two overs
    clear_main(1'b0);
    for (int b = 0; b < 12; b++) deliver(3, b % 3);
    chk("singles.over", m_over, 1);
    dbusy = 1'b0;
    m_bowl = 1'b1;
    m_ack  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (m_busy) dbusy = 1'b1;
    end
    m_bowl = 1'b0; m_ack = 1'b0;
    chk("done.busy", dbusy, 0);
    chk("done.hold", m_over, 1);
    check_totals("done");

    // ten wickets end the innings before the overs run out
    clear_main(1'b1);
    for (int b = 0; b < 10; b++) deliver(15, 0);
    chk("allout.over", m_over, 1);

    // new_innings from DONE, then abort during ROLL
    clear_main(1'b1);
    deliver(7, 0);
    m_bowl = 1'b1;
    tick();
    m_bowl = 1'b0;
    tick(); tick(); tick();
    m_new = 1'b1;
    tick();
    m_new = 1'b0;
    model_clear();
    chk("abort.busy", m_busy, 0);
    chk("abort.valid", m_valid, 0);
    check_totals("abort");
    seen = 0;
    for (int i = 0; i < R + 6; i++) begin
      tick();
      if (m_valid || m_busy) seen = 1;
    end
    chk("abort.nopulse", seen, 0);

    // reset while showing a result
    m_bowl = 1'b1;
    m_rand = 4'd10;
    tick();
    m_bowl = 1'b0;
    for (int i = 0; i < R + 1; i++) tick();
    chk("midshow.valid", m_valid, 1);
    clear_main(1'b0);

    // randomized innings
    for (int inn = 0; inn < 4; inn++) begin
      clear_main(inn[0]);
      for (int b = 0; b < 40 && model_done() == 0; b++)
        deliver($urandom_range(0, 15), $urandom_range(0, 3));
      chk("rand.over", m_over, model_done());
    end

    // saturation on the long-innings instance
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    chk("sat.clr", s_score, 0);
    sat_exp = 0;
    for (int b = 0; b < 105; b++) begin
      sat_deliver(12 + (b % 2), ok);
      sat_exp = (sat_exp + 6 > 511) ? 511 : sat_exp + 6;
      if (ok == 0) chk("sat.valid", ok, 1);
      if (b >= 80 || b % 20 == 0) chk("sat.score", s_score, sat_exp);
    end
    chk("sat.over", s_over, 1);
    chk("sat.overs", s_overs, 15);
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    s_bowl = 1'b1;
    s_rand = 4'd12;
    tick();
    s_bowl = 1'b0;
    tick(); tick();
    chk("sat.show", s_valid, 1);
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    chk("sat.rst.valid", s_valid, 0);
    chk("sat.rst.score", s_score, 0);
    chk("sat.rst.balls", s_balls, 0);
    chk("sat.rst.runs",  s_runs,  0);
    chk("sat.rst.busy",  s_busy,  0);
    chk("sat.rst.misc",  {s_wkt, s_wkts, s_overs, s_over, s_new}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/delivery_scheduler.md
Name: delivery_scheduler

Overview:
Sequences the shared 4-bit LFSR random source into ball-by-ball outcomes for the cricket game. Each bowl request starts a fixed decorrelation window, then the block samples the LFSR nibble, maps it to a run/wicket outcome and updates the innings totals. It presents the result to the display/scoreboard logic with a valid/ack handshake. It ends the innings on an over or wicket limit.

Parameters:
ROLL_CYCLES, 8, cycles spent in ROLL before sampling rand_in (range 1..255)
BALLS_PER_OVER, 6, legal deliveries per over (range 1..7)
OVERS, 2, overs per innings (range 1..15)
MAX_WICKETS, 10, wickets that end the innings (range 1..15)

Ports:
clk_fpga  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high; clears all state
rand_in  in  4  LFSR output nibble (lfsr_out)
bowl  in  1  delivery request; acted on only in IDLE
new_innings  in  1  clears totals, aborts any delivery, returns to IDLE
result_ack  in  1  consumer accepts current result; acted on only in SHOW
result_valid  out  1  outcome and totals valid; held until acked
outcome_runs  out  3  runs on last ball: 0,1,2,3,4,6
outcome_wicket  out  1  last ball was a wicket; runs=0 when set
score  out  9  innings runs, saturates at 511
wickets  out  4  wickets fallen
balls_in_over  out  3  balls bowled in current over, 0..BALLS_PER_OVER-1
overs_done  out  4  completed overs
busy  out  1  high in ROLL, UPDATE, SHOW
innings_over  out  1  high in DONE

Behaviour:
- Reset or new_innings: state=IDLE. All outputs are 0 and the roll counter is 0. Reset and new_innings take priority over every other input in every state.
- FSM states: IDLE, ROLL, UPDATE, SHOW, DONE.
- IDLE: bowl=1 -> ROLL and the counter loads 0. Otherwise stay in IDLE. result_ack is ignored.
- ROLL:
  - The counter increments every cycle.
  - When the counter equals ROLL_CYCLES-1, rand_in is captured into an internal register and the state moves to UPDATE.
  - bowl is ignored.
- Timing: bowl is high in cycle 0. ROLL occupies cycles 1..ROLL_CYCLES. rand_in is sampled at the end of cycle ROLL_CYCLES. UPDATE is cycle ROLL_CYCLES+1. result_valid and the new totals are visible from cycle ROLL_CYCLES+2.
- Mapping from the captured nibble:
  - 0..2 -> 0 runs
  - 3..6 -> 1 run
  - 7..8 -> 2 runs
  - 9 -> 3 runs
  - 10..11 -> 4 runs
  - 12..13 -> 6 runs
  - 14..15 -> wicket, 0 runs
- UPDATE (single cycle):
  - Registers outcome_runs and outcome_wicket.
  - score += runs, saturating at 511.
  - wickets += 1 on a wicket.
  - balls_in_over += 1. If it reaches BALLS_PER_OVER it wraps to 0 and overs_done += 1.
  - Sets result_valid=1 and moves to SHOW.
- SHOW:
  - result_valid=1 and all outputs are stable.
  - result_ack=1 -> result_valid=0 on the next cycle.
  - The next state is DONE if wickets==MAX_WICKETS or overs_done==OVERS (post-update values); otherwise IDLE.
  - bowl is ignored, including when it is asserted in the same cycle as the ack.
- DONE:
  - innings_over=1 and the totals hold.
  - bowl and result_ack are ignored.
  - Only new_innings or reset leaves DONE.
- busy is decoded combinationally from the state.
- A new_innings during ROLL, UPDATE or SHOW discards the pending delivery. No result_valid pulse is produced for it.
- The last-ball outcome outputs hold their values in IDLE until the next UPDATE. They are cleared only by reset or new_innings.

Test Plan:
- Reset, then a bowl pulse with rand_in held at 4'd12 -> result_valid rises in cycle 10 (ROLL_CYCLES=8). Outputs: outcome_runs=6, score=6, balls_in_over=1, busy high in cycles 1..9 and while in SHOW.
- Hold result_ack low for 20 cycles in SHOW, pulsing bowl -> result_valid stays 1 and the totals do not change. Then ack=1 -> result_valid=0 next cycle and state IDLE.
- Six deliveries with rand_in=4'd3 -> balls_in_over goes 1..5 then 0, overs_done=1, score=6. After 12 deliveries -> innings_over=1 and a further bowl has no effect.
- Ten deliveries with rand_in=4'd15 -> wickets=10, score=0, outcome_wicket=1. innings_over is set after the 10th ack while overs_done=1.
- new_innings asserted in cycle 4 of ROLL -> the next cycle shows IDLE with all totals 0. No result_valid pulse occurs.
- Repeated 6s with OVERS=15 and BALLS_PER_OVER=7 -> score saturates at 511 and stays at 511. Reset mid-SHOW -> all outputs 0 on the next cycle.
